cve2_xif_coproc_ctrl: RTL and testbench

CVE2_XIF_COPROC_CTRL -- requirements
Module: cve2_xif_coproc_ctrl

---
 rtl/cve2_xif_coproc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cve2_xif_coproc_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_xif_coproc_ctrl.sv
// XIF coprocessor controller: accepts custom-opcode ALU instructions (add/xor/sub),
// collects operands, executes for LATENCY cycles and returns one result per instruction.
//
// state    | meaning
// IDLE     | ready for a new issue request
// OPERANDS | instruction accepted, waiting for rs1/rs2
// EXEC     | counting down the execute latency
// RESULT   | result computed, presented once the instruction is committed
module cve2_xif_coproc_ctrl #(
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned X_HARTID_WIDTH = 1,
    parameter int unsigned LATENCY        = 3,
    parameter logic [6:0]  CUSTOM_OPCODE  = 7'h0B
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [31:0]               issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]     issue_id_i,
    input  logic [X_HARTID_WIDTH-1:0] issue_hartid_i,
    output logic                      issue_accept_o,
    output logic                      issue_writeback_o,
    output logic [1:0]                issue_register_read_o,
    output logic                      issue_ecswrite_o,
    input  logic                      register_valid_i,
    output logic                      register_ready_o,
    input  logic [X_ID_WIDTH-1:0]     register_id_i,
    input  logic [63:0]               register_rs_i,
    input  logic [1:0]                register_rs_valid_i,
    input  logic                      commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]     commit_id_i,
    input  logic                      commit_kill_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [X_ID_WIDTH-1:0]     result_id_o,
    output logic [X_HARTID_WIDTH-1:0] result_hartid_o,
    output logic [31:0]               result_data_o,
    output logic [4:0]                result_rd_o,
    output logic                      result_we_o,
    output logic                      result_exc_o,
    output logic [5:0]                result_exccode_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_OPERANDS = 2'd1;
    localparam logic [1:0] S_EXEC     = 2'd2;
    localparam logic [1:0] S_RESULT   = 2'd3;

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [1:0]                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_committed;
    logic [X_ID_WIDTH-1:0]     r_id;
    logic [X_HARTID_WIDTH-1:0] r_hartid;
    logic [4:0]                r_rd;
    logic [2:0]                r_funct3;
    logic [31:0]               r_rs1;
    logic [31:0]               r_rs2;
    logic [31:0]               r_result;

    logic       w_accept;
    logic       w_issue_hs;
    logic       w_reg_hs;
    logic       w_commit_match;
    logic       w_commit;
    logic       w_kill;
    logic       w_result_hs;
    logic [2:0] w_funct3;
    logic       w_unused_instr;

    assign w_funct3       = issue_instr_i[14:12];
    assign w_unused_instr = ^issue_instr_i[24:15];

    assign w_accept = !rst_i
                   && (issue_instr_i[6:0] == CUSTOM_OPCODE)
                   && (w_funct3 <= 3'd2)
                   && (issue_instr_i[31:25] == 7'd0);

    assign issue_ready_o         = (r_state == S_IDLE) && !rst_i;
    assign issue_accept_o        = w_accept;
    assign issue_writeback_o     = w_accept;
    assign issue_register_read_o = w_accept ? 2'b11 : 2'b00;
    assign issue_ecswrite_o      = 1'b0;

    assign register_ready_o = (r_state == S_OPERANDS) && !rst_i;

    assign result_valid_o   = (r_state == S_RESULT) && r_committed && !rst_i;
    assign result_we_o      = result_valid_o;
    assign result_id_o      = r_id;
    assign result_hartid_o  = r_hartid;
    assign result_data_o    = r_result;
    assign result_rd_o      = r_rd;
    assign result_exc_o     = 1'b0;
    assign result_exccode_o = 6'd0;

    assign w_issue_hs     = issue_valid_i && issue_ready_o;
    assign w_reg_hs       = register_valid_i && register_ready_o
                         && (register_id_i == r_id) && (register_rs_valid_i == 2'b11);
    assign w_commit_match = commit_valid_i && (commit_id_i == r_id) && (r_state != S_IDLE);
    assign w_commit       = w_commit_match && !commit_kill_i;
    assign w_kill         = w_commit_match && commit_kill_i;
    assign w_result_hs    = result_valid_o && result_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_committed <= 1'b0;
            r_id        <= '0;
            r_hartid    <= '0;
            r_rd        <= '0;
            r_funct3    <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_result    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_issue_hs && w_accept) begin
                r_id     <= issue_id_i;
                r_hartid <= issue_hartid_i;
                r_rd     <= issue_instr_i[11:7];
                r_funct3 <= w_funct3;
                // The commit may arrive together with the issue, before r_id holds the ID
                r_committed <= commit_valid_i && !commit_kill_i && (commit_id_i == issue_id_i);
                r_state     <= S_OPERANDS;
            end
        end else if (w_kill) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_committed <= 1'b0;
        end else begin
            if (w_commit) begin
                r_committed <= 1'b1;
            end
            case (r_state)
                S_OPERANDS: begin
                    if (w_reg_hs) begin
                        r_rs1   <= register_rs_i[31:0];
                        r_rs2   <= register_rs_i[63:32];
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        case (r_funct3)
                            3'd0:    r_result <= r_rs1 + r_rs2;
                            3'd1:    r_result <= r_rs1 ^ r_rs2;
                            default: r_result <= r_rs1 - r_rs2;
                        endcase
                        r_state <= S_RESULT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (w_result_hs) begin
                        r_committed <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cve2_xif_coproc_ctrl.sv
// Directed bench for cve2_xif_coproc_ctrl: add/xor/sub flows, reject, late commit,
// backpressure, kill and asynchronous reset, with hand-computed expectations.
module tb_cve2_xif_coproc_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [3:0]  issue_id_i;
    logic [0:0]  issue_hartid_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic [1:0]  issue_register_read_o;
    logic        issue_ecswrite_o;
    logic        register_valid_i;
    logic        register_ready_o;
    logic [3:0]  register_id_i;
    logic [63:0] register_rs_i;
    logic [1:0]  register_rs_valid_i;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [0:0]  result_hartid_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic        result_exc_o;
    logic [5:0]  result_exccode_o;

    int n_pass  = 0;
    int n_total = 0;

    cve2_xif_coproc_ctrl #(
        .X_ID_WIDTH(4), .X_HARTID_WIDTH(1), .LATENCY(3), .CUSTOM_OPCODE(7'h0B)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_hartid_i(issue_hartid_i), .issue_accept_o(issue_accept_o),
        .issue_writeback_o(issue_writeback_o),
        .issue_register_read_o(issue_register_read_o),
        .issue_ecswrite_o(issue_ecswrite_o),
        .register_valid_i(register_valid_i), .register_ready_o(register_ready_o),
        .register_id_i(register_id_i), .register_rs_i(register_rs_i),
        .register_rs_valid_i(register_rs_valid_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_hartid_o(result_hartid_o),
        .result_data_o(result_data_o), .result_rd_o(result_rd_o),
        .result_we_o(result_we_o), .result_exc_o(result_exc_o),
        .result_exccode_o(result_exccode_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_i               = 1'b1;
        issue_valid_i       = 1'b1;
        issue_instr_i       = 32'h0020818B;
        issue_id_i          = 4'd3;
        issue_hartid_i      = 1'b1;
        register_valid_i    = 1'b0;
        register_id_i       = 4'd0;
        register_rs_i       = 64'd0;
        register_rs_valid_i = 2'b00;
        commit_valid_i      = 1'b0;
        commit_id_i         = 4'd0;
        commit_kill_i       = 1'b0;
        result_ready_i      = 1'b0;

        // reset: everything low, even with a valid add on the issue port
        step(); step();
        check("rst_issue_ready", issue_ready_o, 0);
        check("rst_accept", issue_accept_o, 0);
        check("rst_regread", issue_register_read_o, 0);
        check("rst_reg_ready", register_ready_o, 0);
        check("rst_result_valid", result_valid_o, 0);
        check("rst_result_data", result_data_o, 0);
        issue_valid_i = 1'b0;
        rst_i = 1'b0;
        #1;
        check("post_rst_issue_ready", issue_ready_o, 1);

        // add, commit during EXEC
        issue_valid_i = 1'b1;
        #1;
        check("add_accept", issue_accept_o, 1);
        check("add_writeback", issue_writeback_o, 1);
        check("add_regread", issue_register_read_o, 2'b11);
        check("add_ecswrite", issue_ecswrite_o, 0);
        step();
        issue_valid_i = 1'b0;
        check("add_reg_ready", register_ready_o, 1);
        check("add_issue_busy", issue_ready_o, 0);
        register_valid_i    = 1'b1;
        register_id_i       = 4'd2;
        register_rs_valid_i = 2'b11;
        register_rs_i       = {32'd7, 32'd5};
        step();
        check("wrong_id_ignored", register_ready_o, 1);
        register_id_i       = 4'd3;
        register_rs_valid_i = 2'b01;
        step();
        check("partial_rs_ignored", register_ready_o, 1);
        register_rs_valid_i = 2'b11;
        step();
        register_valid_i = 1'b0;
        check("add_in_exec", register_ready_o, 0);
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd3;
        step();
        commit_valid_i = 1'b0;
        check("add_lat1", result_valid_o, 0);
        step();
        check("add_lat2", result_valid_o, 0);
        step();
        check("add_valid", result_valid_o, 1);
        check("add_data", result_data_o, 32'd12);
        check("add_rd", result_rd_o, 5'd3);
        check("add_id", result_id_o, 4'd3);
        check("add_hartid", result_hartid_o, 1'b1);
        check("add_we", result_we_o, 1);
        check("add_exc", result_exc_o, 0);
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        check("add_done_valid", result_valid_o, 0);
        check("add_done_ready", issue_ready_o, 1);

        // rejects: wrong opcode, funct3=3, funct7!=0
        issue_instr_i = 32'h002081B3;
        issue_valid_i = 1'b1;
        #1;
        check("rej_accept", issue_accept_o, 0);
        check("rej_writeback", issue_writeback_o, 0);
        check("rej_regread", issue_register_read_o, 0);
        step();
        issue_valid_i = 1'b0;
        check("rej_issue_ready", issue_ready_o, 1);
        check("rej_reg_ready", register_ready_o, 0);
        issue_instr_i = 32'h0020B18B;
        #1;
        check("rej_funct3", issue_accept_o, 0);
        issue_instr_i = 32'h0220818B;
        #1;
        check("rej_funct7", issue_accept_o, 0);

        // sub, late commit, backpressure
        issue_instr_i  = 32'h0020A18B;
        issue_id_i     = 4'd4;
        issue_hartid_i = 1'b0;
        issue_valid_i  = 1'b1;
        step();
        issue_valid_i       = 1'b0;
        register_valid_i    = 1'b1;
        register_id_i       = 4'd4;
        register_rs_i       = {32'd2, 32'd1};
        register_rs_valid_i = 2'b11;
        step();
        register_valid_i = 1'b0;
        step(); step(); step();
        check("sub_no_commit", result_valid_o, 0);
        step();
        check("sub_still_waiting", result_valid_o, 0);
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd5;
        step();
        check("sub_wrong_commit", result_valid_o, 0);
        commit_id_i = 4'd4;
        step();
        commit_valid_i = 1'b0;
        check("sub_valid", result_valid_o, 1);
        check("sub_data", result_data_o, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_valid", result_valid_o, 1);
            check("bp_data", result_data_o, 32'hFFFFFFFF);
            check("bp_id", result_id_o, 4'd4);
            check("bp_we", result_we_o, 1);
        end
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        check("sub_done", result_valid_o, 0);

        // kill in EXEC
        issue_instr_i = 32'h0020818B;
        issue_id_i    = 4'd3;
        issue_valid_i = 1'b1;
        step();
        issue_valid_i    = 1'b0;
        register_valid_i = 1'b1;
        register_id_i    = 4'd3;
        register_rs_i    = {32'd7, 32'd5};
        step();
        register_valid_i = 1'b0;
        commit_valid_i   = 1'b1;
        commit_kill_i    = 1'b1;
        commit_id_i      = 4'd3;
        step();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
        check("kill_idle", issue_ready_o, 1);
        check("kill_reg_ready", register_ready_o, 0);
        for (int i = 0; i < 4; i++) begin
            check("kill_no_result", result_valid_o, 0);
            step();
        end

        // kill beats a simultaneous register handshake
        issue_id_i    = 4'd6;
        issue_valid_i = 1'b1;
        #1;
        check("after_kill_accept", issue_accept_o, 1);
        step();
        issue_valid_i = 1'b0;
        check("after_kill_operands", register_ready_o, 1);
        register_valid_i = 1'b1;
        register_id_i    = 4'd6;
        commit_valid_i   = 1'b1;
        commit_kill_i    = 1'b1;
        commit_id_i      = 4'd6;
        step();
        register_valid_i = 1'b0;
        commit_valid_i   = 1'b0;
        commit_kill_i    = 1'b0;
        check("kill_prio_idle", issue_ready_o, 1);
        step(); step(); step(); step();
        check("kill_prio_no_result", result_valid_o, 0);

        // xor with commit in the same cycle as the issue
        issue_instr_i  = 32'h0020918B;
        issue_id_i     = 4'd5;
        issue_valid_i  = 1'b1;
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd5;
        step();
        issue_valid_i    = 1'b0;
        commit_valid_i   = 1'b0;
        register_valid_i = 1'b1;
        register_id_i    = 4'd5;
        register_rs_i    = {32'h000000FF, 32'h000000F0};
        step();
        register_valid_i = 1'b0;
        step(); step();
        check("xor_lat", result_valid_o, 0);
        step();
        check("xor_valid", result_valid_o, 1);
        check("xor_data", result_data_o, 32'h0000000F);
        check("xor_id", result_id_o, 4'd5);
        check("xor_rd", result_rd_o, 5'd3);

        // asynchronous reset while a result is on offer
        rst_i = 1'b1;
        #1;
        check("arst_valid", result_valid_o, 0);
        check("arst_issue_ready", issue_ready_o, 0);
        check("arst_data", result_data_o, 0);
        step();
        rst_i = 1'b0;
        #1;
        check("arst_release_ready", issue_ready_o, 1);
        step();
        check("arst_release_valid", result_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
